// File: rtl/shreg_ctrl_pkg.sv
// Shared encodings and defaults for the shift-register command sequencer.
package shreg_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_AMT_W     = 3;
    localparam int unsigned DEF_PULSE_CYC = 1;
    localparam int unsigned DEF_GAP_CYC   = 1;

    // Larger of two unsigned values, used to size the phase timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter timing the PULSE and GAP phases.
//   clk      : clock
//   reset    : synchronous active-high reset
//   load     : reload the counter with load_val
//   load_val : cycles remaining in the phase minus one
//   expired  : registered flag, high while the count is zero
module pulse_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // expired is tracked alongside the count so it comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b1;
        end else if (load) begin
            count   <= load_val;
            expired <= (load_val == '0);
        end else if (count != '0) begin
            count   <= count - CNT_W'(1);
            expired <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a shift register: turns one LOAD / SHL N / SHR N
// command into timed, mutually exclusive ld/sl/sr strobes.
//   clk, reset : clock, synchronous active-high reset
//   start      : command request, sampled only in IDLE
//   op         : 00 NOP, 01 LOAD, 10 SHL, 11 SHR
//   amount     : shift count for SHL/SHR
//   d_in       : load data, captured with every accepted command
//   busy       : high while a command is in progress
//   done       : one-cycle completion pulse
//   ld, sl, sr : register strobes
//   d_out      : data presented to the register
module shift_reg_sequencer
    import shreg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned AMT_W     = DEF_AMT_W,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic             ld,
    output logic             sl,
    output logic             sr,
    output logic [WIDTH-1:0] d_out
);

    localparam int unsigned TMR_W = $clog2(max_u(PULSE_CYC, GAP_CYC)) + 1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expired;
    logic               busy_d, done_d, ld_d, sl_d, sr_d;

    pulse_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next state, latches and timer control; outputs are decoded from the
    // next state so the registered strobes line up with the state register.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        data_d   = d_out;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op_e'(op);
                    data_d = d_in;
                    case (op_e'(op))
                        OP_LOAD:        cnt_d = AMT_W'(1);
                        OP_SHL, OP_SHR: cnt_d = amount;
                        default:        cnt_d = '0;
                    endcase
                    if (cnt_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(PULSE_CYC - 1);
                    end
                end
            end
            PULSE: begin
                if (tmr_expired) begin
                    state_d  = GAP;
                    cnt_d    = cnt_q - AMT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    if (cnt_q != '0) begin
                        state_d  = PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(PULSE_CYC - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ld_d   = (state_d == PULSE) && (op_d == OP_LOAD);
        sl_d   = (state_d == PULSE) && (op_d == OP_SHL);
        sr_d   = (state_d == PULSE) && (op_d == OP_SHR);
    end

    // State, latches and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            d_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ld      <= 1'b0;
            sl      <= 1'b0;
            sr      <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            d_out   <= data_d;
            busy    <= busy_d;
            done    <= done_d;
            ld      <= ld_d;
            sl      <= sl_d;
            sr      <= sr_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer: directed table, corner
// sequences, random commands and a PULSE_CYC=2/GAP_CYC=3 variant.
module tb_shift_reg_sequencer;

    localparam logic [1:0] T_NOP  = 2'b00;
    localparam logic [1:0] T_LOAD = 2'b01;
    localparam logic [1:0] T_SHL  = 2'b10;
    localparam logic [1:0] T_SHR  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start1;
    logic [1:0] op, op1;
    logic [2:0] amount, amount1;
    logic [3:0] d_in, d_in1;
    logic       busy, done, ld, sl, sr;
    logic [3:0] d_out;
    logic       busy1, done1, ld1, sl1, sr1;
    logic [3:0] d_out1;

    int  checks   = 0;
    int  failures = 0;
    bit  inv_en   = 1'b0;

    always #5 clk = ~clk;

    shift_reg_sequencer u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .amount (amount),
        .d_in   (d_in),
        .busy   (busy),
        .done   (done),
        .ld     (ld),
        .sl     (sl),
        .sr     (sr),
        .d_out  (d_out)
    );

    shift_reg_sequencer #(
        .WIDTH     (4),
        .AMT_W     (3),
        .PULSE_CYC (2),
        .GAP_CYC   (3)
    ) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start1),
        .op     (op1),
        .amount (amount1),
        .d_in   (d_in1),
        .busy   (busy1),
        .done   (done1),
        .ld     (ld1),
        .sl     (sl1),
        .sr     (sr1),
        .d_out  (d_out1)
    );

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Strobes must be exclusive and never coincide with done.
    always @(negedge clk) begin
        if (inv_en) begin
            check("exclusive_strobes", 0, 32'(($countones({ld, sl, sr}) <= 1) && !(done && (ld | sl | sr))), 1);
            check("exclusive_strobes_v", 0, 32'(($countones({ld1, sl1, sr1}) <= 1) && !(done1 && (ld1 | sl1 | sr1))), 1);
        end
    end

    function automatic int n_pulses(input logic [1:0] o, input logic [2:0] a);
        case (o)
            T_LOAD:       return 1;
            T_SHL, T_SHR: return int'(a);
            default:      return 0;
        endcase
    endfunction

    task automatic check_idle(input string name, input logic [3:0] exp_d);
        check({name, "_busy"}, 0, 32'(busy), 0);
        check({name, "_done"}, 0, 32'(done), 0);
        check({name, "_strobes"}, 0, 32'({ld, sl, sr}), 0);
        check({name, "_d_out"}, 0, 32'(d_out), 32'(exp_d));
    endtask

    // Issue one command from an IDLE cycle and check every cycle until the
    // following IDLE cycle. Ends before that IDLE cycle's edge, so a held or
    // re-asserted start is accepted exactly one cycle after done.
    task automatic run_cmd(input logic [1:0] o, input logic [2:0] a, input logic [3:0] d,
                           input bit hold, input bit poke, input int exp_n,
                           input int exp_done);
        int  n_len;
        int  seen;
        int  done_at;
        bit  st;
        start  = 1'b1;
        op     = o;
        amount = a;
        d_in   = d;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n_len   = exp_n * 2 + 1;
        seen    = 0;
        done_at = -1;
        for (int c = 1; c <= n_len; c++) begin
            if (poke && c == 2) begin
                start = 1'b1;
                op    = T_LOAD;
                d_in  = ~d;
            end else if (poke && c == 4) begin
                start = 1'b0;
            end
            st = (c < n_len) && (((c - 1) % 2) == 0);
            check("busy", c, 32'(busy), 1);
            check("done", c, 32'(done), 32'(c == n_len));
            check("ld", c, 32'(ld), 32'(st && o == T_LOAD));
            check("sl", c, 32'(sl), 32'(st && o == T_SHL));
            check("sr", c, 32'(sr), 32'(st && o == T_SHR));
            check("d_out", c, 32'(d_out), 32'(d));
            if (ld | sl | sr) seen++;
            if (done) done_at = c;
            @(posedge clk); #1;
        end
        check_idle("after_done", d);
        check("strobe_count", 0, 32'(seen), 32'(exp_n));
        check("done_cycle", 0, 32'(done_at), 32'(exp_done));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] amt;
        logic [3:0] d;
        bit         hold;
        bit         poke;
        int         exp_n;
        int         exp_done;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [1:0] r_op;
        logic [2:0] r_amt;
        logic [3:0] r_d;
        bit         r_hold;

        tbl[0] = '{T_LOAD, 3'd5, 4'b1011, 1'b0, 1'b0, 1, 3};
        tbl[1] = '{T_SHL,  3'd2, 4'b1011, 1'b1, 1'b0, 2, 5};
        tbl[2] = '{T_SHR,  3'd1, 4'b1011, 1'b0, 1'b0, 1, 3};
        tbl[3] = '{T_NOP,  3'd3, 4'b0101, 1'b0, 1'b0, 0, 1};
        tbl[4] = '{T_SHL,  3'd0, 4'b1110, 1'b0, 1'b0, 0, 1};
        tbl[5] = '{T_SHR,  3'd5, 4'b0010, 1'b0, 1'b1, 5, 11};
        tbl[6] = '{T_SHL,  3'd7, 4'b1111, 1'b0, 1'b0, 7, 15};

        reset   = 1'b1;
        start   = 1'b0;
        op      = T_NOP;
        amount  = '0;
        d_in    = '0;
        start1  = 1'b0;
        op1     = T_NOP;
        amount1 = '0;
        d_in1   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 4'h0);
        check("reset_v", 0, 32'({busy1, done1, ld1, sl1, sr1, d_out1}), 0);
        inv_en = 1'b1;
        reset  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_idle("idle", 4'h0);
        end

        foreach (tbl[i])
            run_cmd(tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].hold, tbl[i].poke,
                    tbl[i].exp_n, tbl[i].exp_done);

        // Reset during the second pulse of SHR 4.
        start  = 1'b1;
        op     = T_SHR;
        amount = 3'd4;
        d_in   = 4'b1001;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_sr1", 1, 32'(sr), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_sr3", 3, 32'(sr), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("mid_reset", 4'h0);
        run_cmd(T_LOAD, 3'd0, 4'b0110, 1'b0, 1'b0, 1, 3);

        // Random commands against the arithmetic timing model.
        for (int i = 0; i < 25; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_amt  = 3'($urandom_range(0, 7));
            r_d    = 4'($urandom);
            r_hold = 1'($urandom_range(0, 1));
            run_cmd(r_op, r_amt, r_d, r_hold, 1'b0, n_pulses(r_op, r_amt),
                    2 * n_pulses(r_op, r_amt) + 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("rand_end_busy", 0, 32'(busy), 0);

        // PULSE_CYC=2, GAP_CYC=3: SHL 2.
        start1  = 1'b1;
        op1     = T_SHL;
        amount1 = 3'd2;
        d_in1   = 4'b1010;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check("v_sl", c, 32'(sl1), 32'(c == 1 || c == 2 || c == 6 || c == 7));
            check("v_done", c, 32'(done1), 32'(c == 11));
            check("v_busy", c, 32'(busy1), 32'(c <= 11));
            check("v_ld_sr", c, 32'({ld1, sr1}), 0);
            check("v_d_out", c, 32'(d_out1), 32'(4'b1010));
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
